map_ram_arbiter: RTL and testbench

- Shares the single-port 36x28x8 tile-map RAM between three requesters:
  - the VGA address path, which reads the tile code for the current pixel;
  - game-logic writes (pellet eaten, power-up cleared);
  - game-logic reads (wall and collision checks).
- The VGA path has absolute priority and is never stalled.
- Game writes are buffered in a small FIFO and drained in idle slots. Game reads are ordered after all pending writes.

---
 rtl/map_ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_map_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_ram_arbiter
// Brief    : Shares the single-port tile-map RAM between VGA reads (top
//            priority), buffered game writes and ordered game reads.
// Revision : 1.0 - initial release
// ============================================================================
module map_ram_arbiter #(
    parameter int         ROWS       = 36,
    parameter int         COLS       = 28,
    parameter int         WQ_DEPTH   = 4,
    parameter logic [7:0] BLANK_TILE = 8'h00
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_vga_req,
    input  logic [5:0]                   i_vga_row,
    input  logic [4:0]                   i_vga_col,
    output logic                         o_vga_valid,
    output logic [7:0]                   o_vga_data,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [5:0]                   i_wr_row,
    input  logic [4:0]                   i_wr_col,
    input  logic [7:0]                   i_wr_data,
    input  logic                         i_rd_valid,
    output logic                         o_rd_ready,
    input  logic [5:0]                   i_rd_row,
    input  logic [4:0]                   i_rd_col,
    output logic                         o_rd_data_valid,
    output logic [7:0]                   o_rd_data,
    output logic [$clog2(WQ_DEPTH):0]    o_wq_count,
    output logic                         o_err_oor,
    output logic                         o_ram_en,
    output logic                         o_ram_we,
    output logic [9:0]                   o_ram_addr,
    output logic [7:0]                   o_ram_wdata,
    input  logic [7:0]                   i_ram_rdata
);

    localparam int                PTR_W   = $clog2(WQ_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [5:0]        C_ROWS  = 6'(ROWS);
    localparam logic [4:0]        C_COLS  = 5'(COLS);
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(WQ_DEPTH);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_GAME = 2'd2
    } tag_t;

    // row*28 + col via shift-add
    function automatic logic [9:0] tile_addr(input logic [5:0] row, input logic [4:0] col);
        logic [9:0] r;
        r = {4'b0000, row};
        return (r << 4) + (r << 3) + (r << 2) + {5'b00000, col};
    endfunction

    function automatic logic in_range(input logic [5:0] row, input logic [4:0] col);
        return (row < C_ROWS) && (col < C_COLS);
    endfunction

    logic [9:0]        r_q_addr [WQ_DEPTH];
    logic [7:0]        r_q_data [WQ_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    tag_t              r_tag1;
    logic              r_oor1;
    logic              r_err;

    logic w_q_empty, w_wr_ready, w_push_acc, w_wr_inr, w_enq, w_pop;
    logic w_rd_grant, w_vga_inr, w_rd_inr;
    logic w_en, w_we;
    logic [9:0] w_addr;
    logic [7:0] w_wdata;

    assign w_q_empty  = (r_count == '0);
    assign w_wr_ready = (r_count < C_DEPTH);
    assign w_push_acc = i_wr_valid & w_wr_ready;
    assign w_wr_inr   = in_range(i_wr_row, i_wr_col);
    assign w_enq      = w_push_acc & w_wr_inr;
    assign w_pop      = ~i_vga_req & ~w_q_empty;
    // Reads wait for an empty queue so they always observe earlier writes
    assign w_rd_grant = ~i_vga_req & w_q_empty & i_rd_valid;
    assign w_vga_inr  = in_range(i_vga_row, i_vga_col);
    assign w_rd_inr   = in_range(i_rd_row, i_rd_col);

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (i_vga_req) begin
            if (w_vga_inr) begin
                w_en   = 1'b1;
                w_addr = tile_addr(i_vga_row, i_vga_col);
            end
        end else if (w_pop) begin
            w_en    = 1'b1;
            w_we    = 1'b1;
            w_addr  = r_q_addr[r_rd_ptr];
            w_wdata = r_q_data[r_rd_ptr];
        end else if (w_rd_grant && w_rd_inr) begin
            w_en   = 1'b1;
            w_addr = tile_addr(i_rd_row, i_rd_col);
        end
    end

    // Combinational outputs are forced low while reset is held
    assign o_ram_en    = i_rst_n & w_en;
    assign o_ram_we    = i_rst_n & w_we;
    assign o_ram_addr  = i_rst_n ? w_addr  : 10'd0;
    assign o_ram_wdata = i_rst_n ? w_wdata : 8'd0;
    assign o_rd_ready  = i_rst_n & w_rd_grant;
    assign o_wr_ready  = i_rst_n & w_wr_ready;
    assign o_wq_count  = r_count;
    assign o_err_oor   = r_err;

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_q_addr[r_wr_ptr] <= tile_addr(i_wr_row, i_wr_col);
            r_q_data[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_err           <= 1'b0;
            r_tag1          <= TAG_NONE;
            r_oor1          <= 1'b0;
            o_vga_valid     <= 1'b0;
            o_vga_data      <= 8'h00;
            o_rd_data_valid <= 1'b0;
            o_rd_data       <= 8'h00;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_err <= w_push_acc & ~w_wr_inr;

            if (i_vga_req) begin
                r_tag1 <= TAG_VGA;
                r_oor1 <= ~w_vga_inr;
            end else if (w_rd_grant) begin
                r_tag1 <= TAG_GAME;
                r_oor1 <= ~w_rd_inr;
            end else begin
                r_tag1 <= TAG_NONE;
                r_oor1 <= 1'b0;
            end

            o_vga_valid     <= (r_tag1 == TAG_VGA);
            o_rd_data_valid <= (r_tag1 == TAG_GAME);
            if (r_tag1 == TAG_VGA)  o_vga_data <= r_oor1 ? BLANK_TILE : i_ram_rdata;
            if (r_tag1 == TAG_GAME) o_rd_data  <= r_oor1 ? BLANK_TILE : i_ram_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_ram_arbiter
// Brief    : Directed self-checking bench for map_ram_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vga_req;
    logic [5:0] vga_row;
    logic [4:0] vga_col;
    logic       vga_valid;
    logic [7:0] vga_data;
    logic       wr_valid, wr_ready;
    logic [5:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [5:0] rd_row;
    logic [4:0] rd_col;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic [2:0] wq_count;
    logic       err_oor;
    logic       ram_en, ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [0:1023];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    map_ram_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_vga_req(vga_req), .i_vga_row(vga_row), .i_vga_col(vga_col),
        .o_vga_valid(vga_valid), .o_vga_data(vga_data),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
        .i_rd_valid(rd_valid), .o_rd_ready(rd_ready),
        .i_rd_row(rd_row), .i_rd_col(rd_col),
        .o_rd_data_valid(rd_data_valid), .o_rd_data(rd_data),
        .o_wq_count(wq_count), .o_err_oor(err_oor),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    // Single-port RAM with one cycle read latency
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] a_row [6];
    logic [4:0] a_col [6];
    logic [7:0] a_exp [6];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[30]  = 8'h05;
        ram_rdata = 8'h00;
        rst_n = 1'b0;
        vga_req = 0; vga_row = 0; vga_col = 0;
        wr_valid = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        rd_valid = 0; rd_row = 0; rd_col = 0;
        a_row = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd1, 6'd3};
        a_col = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd2, 5'd4};
        a_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h05, 8'h1A};

        // Reset state
        cyc(); cyc();
        #2;
        check_val("rst_vga_valid", vga_valid, 0);
        check_val("rst_wr_ready", wr_ready, 0);
        check_val("rst_wq_count", wq_count, 0);
        check_val("rst_ram_en", ram_en, 0);
        cyc();
        rst_n = 1'b1;

        // Basic VGA read
        vga_req = 1; vga_row = 1; vga_col = 2;
        #2;
        check_val("vga_addr", ram_addr, 30);
        check_val("vga_en", ram_en, 1);
        check_val("vga_we", ram_we, 0);
        cyc();
        vga_req = 0;
        #2;
        check_val("vga_valid_n1", vga_valid, 0);
        cyc();
        #2;
        check_val("vga_valid_n2", vga_valid, 1);
        check_val("vga_data_n2", vga_data, 8'h05);
        cyc();

        // Fill FIFO while VGA owns the RAM
        vga_req = 1; vga_row = 0; vga_col = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_row = 6'(i); wr_col = 5'(i); wr_data = 8'(8'h10 + i);
            #2;
            check_val($sformatf("fill_ready_%0d", i), wr_ready, (i < 4) ? 1 : 0);
            check_val($sformatf("fill_we_%0d", i), ram_we, 0);
            cyc();
        end
        wr_valid = 0;
        #2;
        check_val("fill_count", wq_count, 4);
        cyc();
        vga_req = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_val($sformatf("drain_we_%0d", i), ram_we, 1);
            check_val($sformatf("drain_addr_%0d", i), ram_addr, i * 28 + i);
            check_val($sformatf("drain_wdata_%0d", i), ram_wdata, 8'h10 + i);
            check_val($sformatf("drain_count_%0d", i), wq_count, 4 - i);
            cyc();
        end
        #2;
        check_val("drain_count_end", wq_count, 0);
        check_val("drain_idle_en", ram_en, 0);
        check_val("drain_idle_wdata", ram_wdata, 0);
        cyc();

        // Write-before-read ordering
        wr_valid = 1; wr_row = 3; wr_col = 4; wr_data = 8'h1A;
        #2;
        check_val("ord_push_ready", wr_ready, 1);
        cyc();
        wr_valid = 0;
        rd_valid = 1; rd_row = 3; rd_col = 4;
        #2;
        check_val("ord_write_we", ram_we, 1);
        check_val("ord_write_addr", ram_addr, 88);
        check_val("ord_rd_ready_blocked", rd_ready, 0);
        cyc();
        #2;
        check_val("ord_rd_ready", rd_ready, 1);
        check_val("ord_rd_en", ram_en, 1);
        check_val("ord_rd_we", ram_we, 0);
        check_val("ord_rd_addr", ram_addr, 88);
        cyc();
        rd_valid = 0;
        #2;
        check_val("ord_rd_valid_n1", rd_data_valid, 0);
        cyc();
        #2;
        check_val("ord_rd_valid_n2", rd_data_valid, 1);
        check_val("ord_rd_data_n2", rd_data, 8'h1A);
        cyc();

        // Out-of-range VGA read and write
        vga_req = 1; vga_row = 36; vga_col = 0;
        #2;
        check_val("oor_vga_en", ram_en, 0);
        cyc();
        vga_req = 0;
        cyc();
        #2;
        check_val("oor_vga_valid", vga_valid, 1);
        check_val("oor_vga_data", vga_data, 8'h00);
        cyc();
        wr_valid = 1; wr_row = 0; wr_col = 28; wr_data = 8'h77;
        #2;
        check_val("oor_wr_ready", wr_ready, 1);
        cyc();
        wr_valid = 0;
        #2;
        check_val("oor_err_pulse", err_oor, 1);
        check_val("oor_wq_count", wq_count, 0);
        check_val("oor_no_we", ram_we, 0);
        cyc();
        #2;
        check_val("oor_err_clear", err_oor, 0);
        cyc();

        // Alternating VGA and game reads
        for (int k = 0; k < 8; k++) begin
            vga_req = 0; rd_valid = 0;
            if (k < 6) begin
                if (k % 2 == 0) begin
                    vga_req = 1; vga_row = a_row[k]; vga_col = a_col[k];
                end else begin
                    rd_valid = 1; rd_row = a_row[k]; rd_col = a_col[k];
                end
            end
            #2;
            if (k < 6 && k % 2 == 1) check_val($sformatf("alt_rd_ready_%0d", k), rd_ready, 1);
            if (k >= 2) begin
                if ((k - 2) % 2 == 0) begin
                    check_val($sformatf("alt_vga_valid_%0d", k), vga_valid, 1);
                    check_val($sformatf("alt_vga_data_%0d", k), vga_data, a_exp[k-2]);
                    check_val($sformatf("alt_rd_quiet_%0d", k), rd_data_valid, 0);
                end else begin
                    check_val($sformatf("alt_rd_valid_%0d", k), rd_data_valid, 1);
                    check_val($sformatf("alt_rd_data_%0d", k), rd_data, a_exp[k-2]);
                    check_val($sformatf("alt_vga_quiet_%0d", k), vga_valid, 0);
                end
            end
            cyc();
        end

        // Reset with reads in flight and a partially full FIFO
        vga_req = 1; vga_row = 0; vga_col = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_row = 6'(5 + i); wr_col = 0; wr_data = 8'(8'hA0 + i);
            cyc();
        end
        wr_valid = 0;
        #2;
        check_val("mid_count_pre", wq_count, 3);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vga_valid", vga_valid, 0);
        check_val("mid_rst_count", wq_count, 0);
        check_val("mid_rst_ram_en", ram_en, 0);
        vga_req = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_val($sformatf("post_vga_valid_%0d", i), vga_valid, 0);
            check_val($sformatf("post_rd_valid_%0d", i), rd_data_valid, 0);
            check_val($sformatf("post_we_%0d", i), ram_we, 0);
            check_val($sformatf("post_count_%0d", i), wq_count, 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
